// File: rtl/herloa_err_monitor_pkg.sv
// herloa_pkg: shared defaults, FSM state type and the error-distance helper
// for the HERLOA (N=16, K=10) error monitor.
//   HL_N     : operand / approximate-sum width
//   HL_K     : approximate lower-part width
//   HL_CNT_W : window length and counter width
package herloa_pkg;

  localparam int HL_N     = 16;
  localparam int HL_K     = 10;
  localparam int HL_CNT_W = 16;

  // Explicit encoding so the state register matches the legacy 2-bit code.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // |exact - approx| where exact carries the adder carry-out and approx does
  // not. The difference spans -(2^N-1) .. 2^(N+1)-2, so N+2 signed bits hold
  // it and the magnitude always fits back into N+1 bits.
  function automatic logic [HL_N:0] ed_calc(input logic [HL_N:0]   exact,
                                            input logic [HL_N-1:0] approx);
    logic signed [HL_N+1:0] diff;
    diff = $signed({1'b0, exact}) - $signed({2'b00, approx});
    return diff[HL_N+1] ? (HL_N+1)'(-diff) : (HL_N+1)'(diff);
  endfunction

endpackage

// File: rtl/herloa_err_monitor_if.sv
// herloa_err_monitor_if: sample stream from the adder under test.
//   in_valid  : a, b, s_approx valid this cycle (master -> slave)
//   in_ready  : monitor accepts a sample this cycle (slave -> master)
//   a, b      : adder operands
//   s_approx  : HERLOA sum, no carry-out
interface herloa_err_monitor_if #(
  parameter int N = herloa_pkg::HL_N
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] s_approx;

  modport master (output in_valid, a, b, s_approx, input in_ready);
  modport slave  (input in_valid, a, b, s_approx, output in_ready);
endinterface

// File: rtl/herloa_err_monitor_ed_stage.sv
// herloa_ed_stage: stage-2 combinational error metrics for one sample.
//   exact      : a + b with carry-out (N+1 bits)
//   approx     : HERLOA sum (N bits)
//   ed         : error distance |exact - approx|
//   err        : ed != 0
//   hi_err     : accurate upper part [N-1:K] differs
//   carry_drop : exact carry-out set (HERLOA has no carry-out to report it)
// ed_calc is sized by the package width, so N must stay at HL_N.
module herloa_ed_stage
  import herloa_pkg::*;
#(
  parameter int N = HL_N,
  parameter int K = HL_K
) (
  input  logic [N:0]   exact,
  input  logic [N-1:0] approx,
  output logic [N:0]   ed,
  output logic         err,
  output logic         hi_err,
  output logic         carry_drop
);
  assign ed         = ed_calc(exact, approx);
  assign err        = |ed;
  assign hi_err     = approx[N-1:K] != exact[N-1:K];
  assign carry_drop = exact[N];
endmodule

// File: rtl/herloa_err_monitor.sv
// herloa_err_monitor: collects HERLOA adder error statistics over a window.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin a window (IDLE only); num_samples latched with it
//   smp             : sample stream (slave side), in_ready high in RUN
//   busy            : RUN or DRAIN
//   done            : one-cycle pulse when results are final
//   sample_cnt      : accepted samples (updated at accept)
//   err_cnt, hi_err_cnt, carry_drop_cnt, sum_ed, max_ed : window metrics
// Two-stage pipe: stage 1 registers exact/approx, stage 2 accumulates.
module herloa_err_monitor
  import herloa_pkg::*;
#(
  parameter int N     = HL_N,
  parameter int K     = HL_K,
  parameter int CNT_W = HL_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_samples,
  herloa_err_monitor_if.slave smp,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    hi_err_cnt,
  output logic [CNT_W-1:0]    carry_drop_cnt,
  output logic [N+CNT_W:0]    sum_ed,
  output logic [N:0]          max_ed
);
  localparam int STAGES = 1;

  state_e           state;
  logic             drain_cnt;
  logic [CNT_W-1:0] num_lat;
  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;
  logic [N:0]       exact_q;
  logic [N-1:0]     approx_q;
  logic             accept, last_acc, clr;
  logic [N:0]       ed;
  logic             err, hi_err, carry_drop;

  assign smp.in_ready = (state == RUN);
  assign busy         = (state == RUN) || (state == DRAIN);
  assign accept       = smp.in_valid & smp.in_ready;
  assign last_acc     = accept && ((sample_cnt + CNT_W'(1)) == num_lat);
  assign clr          = (state == IDLE) && start;
  assign vld_pipe     = {vld_q, accept};

  herloa_ed_stage #(.N(N), .K(K)) u_ed (
    .exact      (exact_q),
    .approx     (approx_q),
    .ed         (ed),
    .err        (err),
    .hi_err     (hi_err),
    .carry_drop (carry_drop)
  );

  // FSM, stage-1 registers and the accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= 1'b0;
      num_lat    <= '0;
      sample_cnt <= '0;
      done       <= 1'b0;
      vld_q      <= '0;
      exact_q    <= '0;
      approx_q   <= '0;
    end else begin
      done  <= 1'b0;
      vld_q <= vld_pipe[STAGES-1:0];
      if (accept) begin
        exact_q  <= {1'b0, smp.a} + {1'b0, smp.b};
        approx_q <= smp.s_approx;
      end
      case (state)
        IDLE: if (start) begin
          sample_cnt <= '0;
          num_lat    <= num_samples;
          // An empty window completes straight away without leaving IDLE.
          if (num_samples != '0) state <= RUN;
          else                   done  <= 1'b1;
        end
        RUN: if (accept) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          if (last_acc) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        // Two cycles: the last sample passes stage 1 then stage 2.
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage-2 accumulators; cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      hi_err_cnt     <= '0;
      carry_drop_cnt <= '0;
      sum_ed         <= '0;
      max_ed         <= '0;
    end else if (clr) begin
      err_cnt        <= '0;
      hi_err_cnt     <= '0;
      carry_drop_cnt <= '0;
      sum_ed         <= '0;
      max_ed         <= '0;
    end else if (vld_pipe[STAGES]) begin
      err_cnt        <= err_cnt + CNT_W'(err);
      hi_err_cnt     <= hi_err_cnt + CNT_W'(hi_err);
      carry_drop_cnt <= carry_drop_cnt + CNT_W'(carry_drop);
      sum_ed         <= sum_ed + {{CNT_W{1'b0}}, ed};
      if (ed > max_ed) max_ed <= ed;
    end
  end
endmodule

// File: tb/tb_herloa_err_monitor.sv
module tb_herloa_err_monitor;
  localparam int N  = 16;
  localparam int K  = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          busy, done;
  logic [CW-1:0] sample_cnt, err_cnt, hi_err_cnt, carry_drop_cnt;
  logic [N+CW:0] sum_ed;
  logic [N:0]    max_ed;

  int checks = 0;
  int errors = 0;

  herloa_err_monitor_if #(.N(N)) smp ();

  herloa_err_monitor #(.N(N), .K(K), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .smp(smp), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .hi_err_cnt(hi_err_cnt), .carry_drop_cnt(carry_drop_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  // Current window's samples and idle cycles before each sample.
  logic [N-1:0] sa[16], sb[16], ss[16];
  int           sgap[16];
  int           start_at = -1;   // sample index that also pulses start

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][15:0] a, b, s;
    logic [3:0][1:0]  gap;
    logic [15:0]      e_err, e_hi, e_cd;
    logic [32:0]      e_sum;
    logic [16:0]      e_max;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: metrics straight from the definitions using integer arithmetic.
  task automatic model(input int n, output logic [15:0] e_err, output logic [15:0] e_hi,
                       output logic [15:0] e_cd, output logic [32:0] e_sum,
                       output logic [16:0] e_max);
    longint ex, d, sum, mx;
    int     ne, nh, nc;
    ne = 0; nh = 0; nc = 0; sum = 0; mx = 0;
    for (int i = 0; i < n; i++) begin
      ex = longint'(sa[i]) + longint'(sb[i]);
      d  = ex - longint'(ss[i]);
      if (d < 0) d = -d;
      if (d != 0) ne++;
      if (((ex >> K) & 63) != (longint'(ss[i]) >> K)) nh++;
      if (ex >= 65536) nc++;
      sum += d;
      if (d > mx) mx = d;
    end
    e_err = 16'(ne); e_hi = 16'(nh); e_cd = 16'(nc);
    e_sum = 33'(sum); e_max = 17'(mx);
  endtask

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic drive_one(input int idx);
    int w;
    smp.in_valid = 1'b1;
    smp.a = sa[idx]; smp.b = sb[idx]; smp.s_approx = ss[idx];
    w = 0;
    while (!smp.in_ready && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (!smp.in_ready) begin
      chk("ready_timeout", 64'(smp.in_ready), 64'd1);
      smp.in_valid = 1'b0;
      return;
    end
    if (idx == start_at) begin
      start = 1'b1;
      num_samples = 16'd1;
    end
    @(posedge clk);
    #1;
    smp.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_window(input string tag, input int n, input logic [15:0] e_err,
                            input logic [15:0] e_hi, input logic [15:0] e_cd,
                            input logic [32:0] e_sum, input logic [16:0] e_max);
    int lat;
    @(negedge clk);
    start = 1'b1;
    num_samples = CW'(n);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      repeat (sgap[i]) @(negedge clk);
      drive_one(i);
    end
    chk({tag, ".rdy_drop"}, 64'(smp.in_ready), 64'd0);
    chk({tag, ".busy_drain"}, 64'(busy), 64'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 12);
    chk({tag, ".done_lat"}, 64'(lat), 64'd3);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
    chk({tag, ".smp"}, 64'(sample_cnt), 64'(n));
    chk({tag, ".err"}, 64'(err_cnt), 64'(e_err));
    chk({tag, ".hi"}, 64'(hi_err_cnt), 64'(e_hi));
    chk({tag, ".cd"}, 64'(carry_drop_cnt), 64'(e_cd));
    chk({tag, ".sum"}, 64'(sum_ed), 64'(e_sum));
    chk({tag, ".max"}, 64'(max_ed), 64'(e_max));
    // start during DONE must be ignored; results hold afterwards.
    start = 1'b1;
    num_samples = 16'd3;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".hold_done"}, 64'(done), 64'd0);
    chk({tag, ".hold_busy"}, 64'(busy), 64'd0);
    chk({tag, ".hold_sum"}, 64'(sum_ed), 64'(e_sum));
  endtask

  task automatic set_smp(input int v, input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic [1:0] g);
    vecs[v].a[i] = a; vecs[v].b[i] = b; vecs[v].s[i] = s; vecs[v].gap[i] = g;
  endtask

  task automatic set_exp(input int v, input logic [2:0] n, input logic [15:0] e_err,
                         input logic [15:0] e_hi, input logic [15:0] e_cd,
                         input logic [32:0] e_sum, input logic [16:0] e_max);
    vecs[v].n = n; vecs[v].e_err = e_err; vecs[v].e_hi = e_hi; vecs[v].e_cd = e_cd;
    vecs[v].e_sum = e_sum; vecs[v].e_max = e_max;
  endtask

  initial begin
    logic [15:0] e_err, e_hi, e_cd;
    logic [32:0] e_sum;
    logic [16:0] e_max;
    int          n, ex, m;

    smp.in_valid = 1'b0; smp.a = '0; smp.b = '0; smp.s_approx = '0;
    for (int v = 0; v < 4; v++) vecs[v] = '0;
    set_smp(0, 0, 16'h00FF, 16'h00FF, 16'h01FE, 2'd0);
    set_exp(0, 3'd1, 16'd0, 16'd0, 16'd0, 33'd0, 17'd0);
    set_smp(1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 2'd0);
    set_exp(1, 3'd1, 16'd1, 16'd0, 16'd1, 33'h10000, 17'h10000);
    set_smp(2, 0, 16'h0001, 16'h0001, 16'h0003, 2'd0);
    set_smp(2, 1, 16'h0000, 16'h0000, 16'h0000, 2'd0);
    set_smp(2, 2, 16'h0300, 16'h0100, 16'h0401, 2'd0);
    set_exp(2, 3'd3, 16'd2, 16'd0, 16'd0, 33'd2, 17'd1);
    set_smp(3, 0, 16'h0400, 16'h0400, 16'h0000, 2'd0);
    set_smp(3, 1, 16'h1000, 16'h0000, 16'h1000, 2'd2);
    set_exp(3, 3'd2, 16'd1, 16'd1, 16'd0, 33'h800, 17'h800);

    // Reset state
    #3 rst_n = 1'b0;
    #10;
    chk("rst.ready", 64'(smp.in_ready), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.smp", 64'(sample_cnt), 64'd0);
    chk("rst.sum", 64'(sum_ed), 64'd0);
    chk("rst.max", 64'(max_ed), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) begin
        sa[i] = vecs[v].a[i]; sb[i] = vecs[v].b[i]; ss[i] = vecs[v].s[i];
        sgap[i] = int'(vecs[v].gap[i]);
      end
      run_window($sformatf("vec%0d", v), int'(vecs[v].n), vecs[v].e_err, vecs[v].e_hi,
                 vecs[v].e_cd, vecs[v].e_sum, vecs[v].e_max);
    end

    // Zero-length window clears results and pulses done without going busy
    @(negedge clk);
    start = 1'b1;
    num_samples = '0;
    @(posedge clk);
    #1 start = 1'b0;
    chk("zero.busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("zero.done", 64'(done), 64'd1);
    chk("zero.busy2", 64'(busy), 64'd0);
    chk("zero.smp", 64'(sample_cnt), 64'd0);
    chk("zero.sum", 64'(sum_ed), 64'd0);
    chk("zero.max", 64'(max_ed), 64'd0);
    @(negedge clk);
    chk("zero.done_pulse", 64'(done), 64'd0);

    // start pulsed mid-RUN is ignored; window still ends at 4
    for (int i = 0; i < 4; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom); ss[i] = 16'($urandom); sgap[i] = 0;
    end
    start_at = 2;
    model(4, e_err, e_hi, e_cd, e_sum, e_max);
    run_window("ign_start", 4, e_err, e_hi, e_cd, e_sum, e_max);
    start_at = -1;

    // Reset mid-window after 2 of 5 samples
    for (int i = 0; i < 2; i++) begin
      sa[i] = 16'hFFFF; sb[i] = 16'hFFFF; ss[i] = 16'hFFFE; sgap[i] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    num_samples = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_one(i);
    end
    @(negedge clk);
    chk("mid.pre_smp", 64'(sample_cnt), 64'd2);
    chk("mid.pre_err", 64'(err_cnt), 64'd1);
    smp.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid.ready", 64'(smp.in_ready), 64'd0);
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.smp", 64'(sample_cnt), 64'd0);
    chk("mid.err", 64'(err_cnt), 64'd0);
    chk("mid.cd", 64'(carry_drop_cnt), 64'd0);
    chk("mid.sum", 64'(sum_ed), 64'd0);
    chk("mid.max", 64'(max_ed), 64'd0);
    @(negedge clk);
    smp.in_valid = 1'b0;
    rst_n = 1'b1;
    sa[0] = 16'h00FF; sb[0] = 16'h00FF; ss[0] = 16'h01FE; sgap[0] = 0;
    run_window("post_rst", 1, 16'd0, 16'd0, 16'd0, 33'd0, 17'd0);

    // Randomized windows against the reference model
    for (int w = 0; w < 25; w++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        sa[i] = 16'($urandom); sb[i] = 16'($urandom);
        ex = int'(sa[i]) + int'(sb[i]);
        m = int'($urandom_range(0, 2));
        if (m == 0)      ss[i] = 16'(ex);
        else if (m == 1) ss[i] = 16'(ex) ^ 16'($urandom_range(0, 1023));
        else             ss[i] = 16'($urandom);
        sgap[i] = int'($urandom_range(0, 2));
      end
      model(n, e_err, e_hi, e_cd, e_sum, e_max);
      run_window($sformatf("rnd%0d", w), n, e_err, e_hi, e_cd, e_sum, e_max);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/herloa_err_monitor.md
Name: herloa_err_monitor

Overview:
- Sequential error-metric collector that sits directly downstream of the HERLOA approximate adder (N=16, K=10).
- Consumes each operand pair (a, b) and the adder's approximate sum, computes the exact sum internally, and accumulates statistics over a programmed sample window:
  - error count
  - upper-part error count
  - summed and maximum error distance
  - dropped-carry count
- Used in characterisation benches and on-chip self-test to quantify adder accuracy without an external golden model.

Parameters:
- N, 16: operand and approximate-sum width.
- K, 10: approximate lower-part width; bits [N-1:K] are the accurate upper part.
- CNT_W, 16: width of the window length and of every counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a window; honoured only in IDLE.
- num_samples  input  CNT_W  window length; sampled when start is accepted.
- in_valid  input  1  a, b, s_approx valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- a  input  N  adder operand A.
- b  input  N  adder operand B.
- s_approx  input  N  HERLOA sum output (no carry-out).
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when results are final.
- sample_cnt  output  CNT_W  samples accepted this window.
- err_cnt  output  CNT_W  samples with ED != 0.
- hi_err_cnt  output  CNT_W  samples where s_approx[N-1:K] != exact[N-1:K].
- carry_drop_cnt  output  CNT_W  samples with exact[N] = 1.
- sum_ed  output  N+CNT_W+1  sum of error distances.
- max_ed  output  N+1  largest error distance in the window.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready, busy and done are 0; all counters, sum_ed and max_ed are 0.
- Arithmetic:
  - exact = a + b, N+1 bits.
  - ED = |exact - {1'b0, s_approx}|, N+1 bits. Compute the difference as N+2 signed, then take the magnitude.
  - sum_ed is zero-extended accumulation and cannot overflow for num_samples <= 2^CNT_W-1.
- Pipeline:
  - Stage 1 registers exact, s_approx and the accept flag.
  - Stage 2 computes ED and the flags and updates the accumulators.
  - A sample accepted in cycle t is reflected in the outputs after edge t+2.
- IDLE:
  - in_ready = 0.
  - start = 1 with num_samples > 0: clear all accumulators, latch num_samples, go to RUN.
  - start = 1 with num_samples = 0: clear accumulators, pulse done the next cycle, stay in IDLE.
- RUN:
  - in_ready = 1 while accepted < latched num_samples.
  - Accept = in_valid & in_ready. sample_cnt increments at accept (stage 1).
  - On the accept that makes the count equal num_samples, in_ready drops the next cycle; go to DRAIN.
  - in_valid gaps are allowed; nothing is counted on idle cycles.
- DRAIN: in_ready = 0; wait exactly 2 cycles for the pipeline to empty, then go to DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- Outputs hold their final values until the next accepted start.
- start while busy or in DONE is ignored; no restart, no clear.
- in_valid while in_ready = 0 is ignored; upstream must hold data. This is not an error.
- Reset mid-window aborts immediately; all outputs return to their reset values.

Decomposition:
- Shared package herloa_pkg holds:
  - default N, K, CNT_W.
  - state enum: IDLE, RUN, DRAIN, DONE.
  - function ed_calc(exact, approx) returning N+1 bits.
- One natural sub-module, herloa_ed_stage: the stage-2 combinational ED and flag calculation. Its outputs are ED, err flag, hi_err flag and carry_drop flag.
- The FSM, counters and pipeline registers live in the top module.

Test Plan:
- Exact sample: start, num_samples=1; a=0x00FF, b=0x00FF, s_approx=0x01FE -> done after 3 cycles in DRAIN/DONE; sample_cnt=1, err_cnt=0, hi_err_cnt=0, sum_ed=0, max_ed=0.
- Dropped carry: num_samples=1; a=0xFFFF, b=0xFFFF, s_approx=0xFFFE -> exact=0x1FFFE; ED=0x10000; err_cnt=1, hi_err_cnt=0, carry_drop_cnt=1, max_ed=0x10000.
- Lower-part-only error: num_samples=3; samples:
  - (0x0001, 0x0001, 0x0003): ED=1.
  - (0x0000, 0x0000, 0x0000): ED=0.
  - (0x0300, 0x0100, 0x0401): ED=1.
  -> err_cnt=2, hi_err_cnt=0, sum_ed=2, max_ed=1, carry_drop_cnt=0.
- Upper-part error with gaps: num_samples=2, in_valid toggling 1-0-0-1:
  - (0x0400, 0x0400, 0x0000): ED=0x800.
  - (0x1000, 0x0000, 0x1000): ED=0.
  -> sample_cnt=2, hi_err_cnt=1, sum_ed=0x800, max_ed=0x800; in_ready=0 after the 2nd accept.
- Zero window and ignored start: start with num_samples=0 -> done next cycle, counters 0, busy never high. Start pulsed during RUN of a 4-sample window -> the window still ends at 4; sample_cnt=4.
- Reset mid-window: assert rst_n=0 after 2 of 5 samples -> all outputs are 0 asynchronously, state IDLE; a fresh start afterwards behaves normally.
